// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32-entry integer register file with two bypassed read
// ports and a per-register pending-write counter used by decode to stall on
// source registers whose producer has not yet written back.
module regfile_scoreboard #(
    parameter int                    CORE             = 0,
    parameter int                    DATA_WIDTH       = 32,
    parameter logic [DATA_WIDTH-1:0] SP_INIT          = '0,
    parameter int                    PRINT_CYCLES_MIN = 1,
    parameter int                    PRINT_CYCLES_MAX = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [4:0]            write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [4:0]            read_sel1,
    input  logic [4:0]            read_sel2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  issue,
    input  logic [4:0]            issue_reg,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  overflow,
    input  logic                  report
);

    logic [DATA_WIDTH-1:0] r_regs [32];
    logic [1:0]            r_cnt [32];
    logic [1:0]            w_cnt_next [32];
    logic                  r_overflow;
    logic                  w_ovf_set;
    logic [31:0]           r_cycles;
    logic                  w_wr_en;
    logic                  w_iss_en;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic                  w_busy1;
    logic                  w_busy2;

    // x0 is never written nor tracked, so both strobes qualify on a nonzero target
    assign w_wr_en  = write && (write_reg != 5'd0);
    assign w_iss_en = issue && (issue_reg != 5'd0);

    // Pending-count next state; a same-register issue and write cancel out
    always_comb begin
        w_ovf_set = 1'b0;
        for (int i = 0; i < 32; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (i != 0) begin
                if (w_iss_en && (issue_reg == 5'(i)) &&
                    !(w_wr_en && (write_reg == 5'(i)))) begin
                    if (r_cnt[i] == 2'd3)
                        w_ovf_set = 1'b1;
                    else
                        w_cnt_next[i] = r_cnt[i] + 2'd1;
                end else if (w_wr_en && (write_reg == 5'(i)) &&
                             !(w_iss_en && (issue_reg == 5'(i)))) begin
                    if (r_cnt[i] != 2'd0)
                        w_cnt_next[i] = r_cnt[i] - 2'd1;
                end
            end
        end
    end

    // Register storage; x2 comes out of reset holding the initial stack pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= (i == 2) ? SP_INIT : '0;
        end else if (w_wr_en) begin
            r_regs[write_reg] <= write_data;
        end
    end

    // Scoreboard counters, sticky overflow flag and free-running cycle count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                r_cnt[i] <= 2'd0;
            r_overflow <= 1'b0;
            r_cycles   <= 32'd0;
        end else begin
            for (int i = 0; i < 32; i++)
                r_cnt[i] <= w_cnt_next[i];
            if (w_ovf_set)
                r_overflow <= 1'b1;
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // Read ports: x0 is hardwired zero, a same-cycle writeback is forwarded
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (read_sel1 != 5'd0)
            w_rd1 = (write && (write_reg == read_sel1)) ? write_data : r_regs[read_sel1];
        if (read_sel2 != 5'd0)
            w_rd2 = (write && (write_reg == read_sel2)) ? write_data : r_regs[read_sel2];
    end

    // Busy: a pending write exists, unless the last one is being forwarded right now
    always_comb begin
        w_busy1 = (read_sel1 != 5'd0) && (r_cnt[read_sel1] != 2'd0) &&
                  !((r_cnt[read_sel1] == 2'd1) && w_wr_en && (write_reg == read_sel1) &&
                    !(w_iss_en && (issue_reg == read_sel1)));
        w_busy2 = (read_sel2 != 5'd0) && (r_cnt[read_sel2] != 2'd0) &&
                  !((r_cnt[read_sel2] == 2'd1) && w_wr_en && (write_reg == read_sel2) &&
                    !(w_iss_en && (issue_reg == read_sel2)));
    end

    assign read_data1 = w_rd1;
    assign read_data2 = w_rd2;
    assign busy1      = w_busy1;
    assign busy2      = w_busy2;
    assign overflow   = r_overflow;

    // Per-cycle trace dump, limited to the configured cycle window
    always @(posedge clock) begin
        if (!reset && report &&
            (r_cycles >= 32'(PRINT_CYCLES_MIN)) && (r_cycles <= 32'(PRINT_CYCLES_MAX)))
            $display("regfile core=%0d cycle=%0d rs1=%0d rd1=%h rs2=%0d rd2=%h busy=%b%b wr=%b x%0d=%h iss=%b x%0d ovf=%b",
                     CORE, r_cycles, read_sel1, w_rd1, read_sel2, w_rd2, w_busy1, w_busy2,
                     write, write_reg, write_data, issue, issue_reg, r_overflow);
    end

endmodule
